// File: rtl/kbd_pkg.sv
// Shared types and helpers for the PS/2 keyboard receive path.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } kbd_state_t;

  localparam int KBD_DATA_BITS = 8;

  // Odd parity: data bits plus the parity bit must hold an odd number of ones.
  function automatic logic kbd_odd_parity_ok(input logic [KBD_DATA_BITS-1:0] data,
                                             input logic                     par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/kbd_rx_ctrl_if.sv
// Scan-code valid/ready stream between the keyboard receiver and its consumer.
interface kbd_rx_ctrl_if;
  import kbd_pkg::*;

  logic [KBD_DATA_BITS-1:0] code;
  logic                     code_valid;
  logic                     code_ready;

  modport master (output code, output code_valid, input code_ready);
  modport slave  (input code, input code_valid, output code_ready);

endinterface

// File: rtl/kbd_fifo.sv
// Small synchronous FIFO; a push while full is dropped (overrun pulse) unless a pop frees a slot that cycle.
module kbd_fifo
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = KBD_DATA_BITS
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              valid,
  output logic              full,
  output logic              overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic              wr_en;

  assign valid = (count != '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop   = valid & ready;
  assign wr_en = push & (~full | pop);
  assign rdata = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push & full & ~pop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/kbd_rx_ctrl.sv
// PS/2 frame receiver: synchronisers, falling-edge detect, frame FSM, watchdog, scan-code FIFO.
// Define KBD_PARITY_CHECK_EN to reject frames whose parity bit is wrong.
module kbd_rx_ctrl
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic          sysclk,
  input  logic          rstn,
  input  logic          kbdclk,
  input  logic          kbddata,
  kbd_rx_ctrl_if.master code_if,
  output logic          frame_err,
  output logic          overrun,
  output logic          busy
);

`ifdef KBD_PARITY_CHECK_EN
  localparam bit PAR_CHECK = 1'b1;
`else
  localparam bit PAR_CHECK = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_DATA   = 2'(DATA);
  localparam logic [1:0] ST_PARITY = 2'(PARITY);
  localparam logic [1:0] ST_STOP   = 2'(STOP);

  localparam int                WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT_CYCLES);

  logic                     kclk_p0, kclk_p1, kclk_p2;
  logic                     kdat_p0, kdat_p1;
  logic                     fall;
  logic                     bit_in;
  logic [1:0]               state;
  logic [2:0]               bit_idx;
  logic [KBD_DATA_BITS-1:0] shreg;
  logic                     par_bit;
  logic [WD_W-1:0]          wd;
  logic                     timeout;
  logic                     stop_edge;
  logic                     par_good;
  logic                     push;
  logic                     full;

  // Stage p0/p1: two-flop synchronisers, idle level 1 out of reset; p2 holds the previous synced clock
  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      kclk_p0 <= 1'b1;
      kclk_p1 <= 1'b1;
      kclk_p2 <= 1'b1;
      kdat_p0 <= 1'b1;
      kdat_p1 <= 1'b1;
    end else begin
      kclk_p0 <= kbdclk;
      kclk_p1 <= kclk_p0;
      kclk_p2 <= kclk_p1;
      kdat_p0 <= kbddata;
      kdat_p1 <= kdat_p0;
    end
  end

  assign fall      = kclk_p2 & ~kclk_p1;
  assign bit_in    = kdat_p1;
  assign stop_edge = fall && (state == ST_STOP);
  assign par_good  = !PAR_CHECK || kbd_odd_parity_ok(shreg, par_bit);
  assign push      = stop_edge && bit_in && par_good;
  // An edge in the same cycle as expiry keeps the frame alive.
  assign timeout   = (state != ST_IDLE) && (wd == WD_MAX) && !fall;
  assign busy      = (state != ST_IDLE);

  // Frame control: state, bit index, watchdog and error pulse
  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      wd        <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= (stop_edge && !(bit_in && par_good)) || timeout;
      if (state == ST_IDLE || fall) wd <= '0;
      else                          wd <= wd + 1'b1;

      if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!bit_in) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end
          ST_DATA: begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: state <= ST_STOP;
          default:   state <= ST_IDLE;
        endcase
      end else if (timeout) begin
        state <= ST_IDLE;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (fall && state == ST_DATA)   shreg[bit_idx] <= bit_in;
    if (fall && state == ST_PARITY) par_bit        <= bit_in;
  end

  kbd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (KBD_DATA_BITS)
  ) u_fifo (
    .clk     (sysclk),
    .rstn    (rstn),
    .push    (push),
    .wdata   (shreg),
    .ready   (code_if.code_ready),
    .rdata   (code_if.code),
    .valid   (code_if.code_valid),
    .full    (full),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_kbd_rx_ctrl.sv
// Directed plus randomized bench for kbd_rx_ctrl against a frame-level queue model.
module tb_kbd_rx_ctrl;

  localparam int TO    = 200;
  localparam int DEPTH = 4;
  localparam int HALF  = 8;

`ifdef KBD_PARITY_CHECK_EN
  localparam bit PAR_CHECK = 1'b1;
`else
  localparam bit PAR_CHECK = 1'b0;
`endif

  logic sysclk = 1'b0;
  logic rstn   = 1'b0;
  logic kbdclk = 1'b1;
  logic kbddata = 1'b1;
  logic frame_err, overrun, busy;

  kbd_rx_ctrl_if cif ();

  kbd_rx_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .sysclk    (sysclk),
    .rstn      (rstn),
    .kbdclk    (kbdclk),
    .kbddata   (kbddata),
    .code_if   (cif),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 sysclk = ~sysclk;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  int ov_cnt  = 0;
  logic [7:0] rx_q[$];

  int exp_err = 0;
  int exp_ov  = 0;
  int occ     = 0;
  logic [7:0] exp_out[$];

  // Inputs change 1 time unit after posedge; everything is observed at negedge.
  always @(negedge sysclk) begin
    if (frame_err === 1'b1) err_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (cif.code_valid === 1'b1 && cif.code_ready === 1'b1) rx_q.push_back(cif.code);
  end

  task automatic cyc();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives nbits of an 11-bit PS/2 frame; optionally pulses code_ready in the push cycle of the stop edge.
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                            input int nbits, input bit pop_at_stop);
    logic [10:0] bits;
    bits[0]    = 1'b0;
    bits[8:1]  = b;
    bits[9]    = (~^b) ^ flip_par;
    bits[10]   = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      kbddata = bits[i];
      repeat (HALF) cyc();
      kbdclk = 1'b0;
      if (i == 10 && pop_at_stop) begin
        cyc();
        cyc();
        cif.code_ready = 1'b1;
        cyc();
        cif.code_ready = 1'b0;
        repeat (HALF - 3) cyc();
      end else begin
        repeat (HALF) cyc();
      end
      kbdclk = 1'b1;
    end
    kbddata = 1'b1;
    repeat (2) cyc();
  endtask

  // Frame-level reference: what a complete frame should do to the buffered codes.
  task automatic model_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                             input bit pop_at_stop);
    bit good;
    good = !bad_stop && !(PAR_CHECK && flip_par);
    if (pop_at_stop && occ > 0) occ--;
    if (!good) exp_err++;
    else if (occ < DEPTH) begin
      occ++;
      exp_out.push_back(b);
    end else exp_ov++;
  endtask

  task automatic frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                       input bit pop_at_stop);
    send_frame(b, flip_par, bad_stop, 11, pop_at_stop);
    model_frame(b, flip_par, bad_stop, pop_at_stop);
  endtask

  task automatic drain(input bit rnd, input string tag);
    int n;
    if (rnd) begin
      for (int i = 0; i < 40; i++) begin
        cif.code_ready = 1'($urandom_range(0, 1));
        cyc();
      end
    end
    cif.code_ready = 1'b1;
    repeat (DEPTH + 4) cyc();
    cif.code_ready = 1'b0;
    cyc();
    occ = 0;
    chk({tag, "_len"}, rx_q.size(), exp_out.size());
    n = (rx_q.size() < exp_out.size()) ? rx_q.size() : exp_out.size();
    for (int i = 0; i < n; i++) chk({tag, "_code"}, rx_q[i], exp_out[i]);
    chk({tag, "_empty"}, cif.code_valid, 1'b0);
    rx_q.delete();
    exp_out.delete();
  endtask

  initial begin
    int nfr;
    int kind;
    logic [7:0] rb;
    cif.code_ready = 1'b0;

    // Reset state
    repeat (3) cyc();
    chk("rst_code", cif.code, 8'h00);
    chk("rst_valid", cif.code_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    rstn = 1'b1;
    repeat (4) cyc();

    // Clean frame
    frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("clean_valid", cif.code_valid, 1'b1);
    chk("clean_code", cif.code, 8'h1C);
    chk("clean_err", err_cnt, exp_err);
    drain(1'b0, "clean");

    // Bad parity
    frame(8'h1C, 1'b1, 1'b0, 1'b0);
    chk("par_err", err_cnt, exp_err);
    chk("par_valid", cif.code_valid, !PAR_CHECK);
    drain(1'b0, "par");

    // Bad stop bit
    frame(8'h5A, 1'b0, 1'b1, 1'b0);
    chk("stop_err", err_cnt, exp_err);
    chk("stop_valid", cif.code_valid, 1'b0);

    // Timeout and recovery
    send_frame(8'h77, 1'b0, 1'b0, 5, 1'b0);
    chk("to_busy_mid", busy, 1'b1);
    repeat (TO + 10) cyc();
    exp_err++;
    chk("to_err", err_cnt, exp_err);
    chk("to_busy", busy, 1'b0);
    frame(8'hF0, 1'b0, 1'b0, 1'b0);
    chk("to_code", cif.code, 8'hF0);
    chk("to_err_after", err_cnt, exp_err);
    drain(1'b0, "to");

    // Overrun on the fifth frame
    frame(8'h1C, 1'b0, 1'b0, 1'b0);
    frame(8'h32, 1'b0, 1'b0, 1'b0);
    frame(8'h21, 1'b0, 1'b0, 1'b0);
    frame(8'h23, 1'b0, 1'b0, 1'b0);
    chk("ovr_none_yet", ov_cnt, 0);
    frame(8'h24, 1'b0, 1'b0, 1'b0);
    chk("ovr_cnt", ov_cnt, exp_ov);
    drain(1'b0, "ovr");

    // Full FIFO with a pop in the push cycle
    frame(8'h1C, 1'b0, 1'b0, 1'b0);
    frame(8'h32, 1'b0, 1'b0, 1'b0);
    frame(8'h21, 1'b0, 1'b0, 1'b0);
    frame(8'h23, 1'b0, 1'b0, 1'b0);
    frame(8'h2B, 1'b0, 1'b0, 1'b1);
    chk("fullpop_ovr", ov_cnt, exp_ov);
    drain(1'b0, "fullpop");

    // Reset mid-frame with a byte buffered
    frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h66, 1'b0, 1'b0, 5, 1'b0);
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    while (occ > 0) begin
      void'(exp_out.pop_back());
      occ--;
    end
    chk("mrst_code", cif.code, 8'h00);
    chk("mrst_valid", cif.code_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    repeat (TO + 10) cyc();
    chk("mrst_err", err_cnt, exp_err);
    frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("mrst_code2", cif.code, 8'h1C);
    drain(1'b0, "mrst");

    // Randomized bursts
    for (int r = 0; r < 8; r++) begin
      nfr = $urandom_range(1, 6);
      for (int f = 0; f < nfr; f++) begin
        rb   = 8'($urandom);
        kind = $urandom_range(0, 9);
        frame(rb, kind == 0, kind == 1, 1'b0);
      end
      chk("rnd_err", err_cnt, exp_err);
      chk("rnd_ovr", ov_cnt, exp_ov);
      drain(1'b1, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
